ym_vrom_mux: RTL and testbench

YM_VROM_MUX -- requirements
Module: ym_vrom_mux

---
 rtl/ym_vrom_mux_if.sv | 43 ++++
 rtl/ym_vrom_mux.sv | 145 ++++++++++++++
 tb/tb_ym_vrom_mux.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ym_vrom_mux_if.sv
// rtl/ym_vrom_mux_if.sv - request/response and V-ROM strobe signals of ym_vrom_mux
//   master : engine side (ym_vrom_mux); takes requests, drives strobes and responses
//   slave  : client / cartridge side
//   B-channel members exist only when VROM_PCMB_EN is defined.
interface ym_vrom_mux_if;
    logic        A_REQ;
    logic [23:0] A_ADDR;
    logic        A_BUSY;
    logic [7:0]  A_DATA;
    logic        A_VALID;
    logic        RMPX;
    logic [1:0]  RA_L;
    logic [3:0]  RA_U;
    logic        nSDROE;
`ifdef VROM_PCMB_EN
    logic        B_REQ;
    logic [23:0] B_ADDR;
    logic        B_BUSY;
    logic [7:0]  B_DATA;
    logic        B_VALID;
    logic        PMPX;
    logic [11:8] PA;
    logic        nSDPOE;
`endif

    modport master (
        input  A_REQ, A_ADDR,
        output A_BUSY, A_DATA, A_VALID, RMPX, RA_L, RA_U, nSDROE
`ifdef VROM_PCMB_EN
        , input  B_REQ, B_ADDR
        , output B_BUSY, B_DATA, B_VALID, PMPX, PA, nSDPOE
`endif
    );

    modport slave (
        output A_REQ, A_ADDR,
        input  A_BUSY, A_DATA, A_VALID, RMPX, RA_L, RA_U, nSDROE
`ifdef VROM_PCMB_EN
        , output B_REQ, B_ADDR
        , input  B_BUSY, B_DATA, B_VALID, PMPX, PA, nSDPOE
`endif
    );
endinterface

// File: rtl/ym_vrom_mux.sv
// rtl/ym_vrom_mux.sv - initiator for the multiplexed YM2610 V-ROM bus (ADPCM-A, optional ADPCM-B)
//   CLK_8M : sole clock, rising edge
//   RESET  : synchronous, active-high
//   bus    : ym_vrom_mux_if.master - A_REQ/A_ADDR in, A_BUSY/A_DATA/A_VALID out,
//            RMPX/RA_L/RA_U/nSDROE strobes out (B equivalents with VROM_PCMB_EN)
//   RAD    : A-channel address-out / data-in bus
//   PAD    : B-channel address-out / data-in bus (VROM_PCMB_EN only)
//   Optional feature macro: VROM_PCMB_EN adds the independent ADPCM-B engine.
module ym_vrom_mux #(
    parameter int RD_CYCLES      = 2,
    parameter int PCMB_RD_CYCLES = 2
) (
    input  logic          CLK_8M,
    input  logic          RESET,
    ym_vrom_mux_if.master bus,
    inout  wire  [7:0]    RAD
`ifdef VROM_PCMB_EN
    ,
    inout  wire  [7:0]    PAD
`endif
);

`ifdef VROM_PCMB_EN
    localparam int NCH = 2;
    wire [NCH-1:0]    req_in  = {bus.B_REQ, bus.A_REQ};
    wire [24*NCH-1:0] addr_in = {bus.B_ADDR, bus.A_ADDR};
    wire [8*NCH-1:0]  ad_in   = {PAD, RAD};
`else
    localparam int NCH = 1;
    wire [NCH-1:0]    req_in  = bus.A_REQ;
    wire [24*NCH-1:0] addr_in = bus.A_ADDR;
    wire [8*NCH-1:0]  ad_in   = RAD;
`endif

    typedef enum logic [2:0] {IDLE, ALO, RISE, AHI, FALL, TURN, READ, DONE} state_t;

    // Channel 0 is ADPCM-A (2 side bits + separate RA_U), channel 1 is ADPCM-B (4 side bits).
    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        localparam int RDC = (ch == 0) ? RD_CYCLES : PCMB_RD_CYCLES;
        localparam int SW  = (ch == 0) ? 2 : 4;
        localparam int LB  = 8 + SW;

        state_t        state_q, state_d;
        logic [3:0]    cnt_q;
        logic [23:0]   addr_q;
        logic          busy_q, valid_q, mpx_q, oe_n_q, ad_oe_q;
        logic [7:0]    ad_q, data_q;
        logic [SW-1:0] side_q;
        logic          accept, last_rd;

        assign last_rd = (cnt_q == 4'(RDC - 1));
        // IDLE with busy_q set is the one-clock address-capture slot after accept.
        // DONE accepts too, so a held request sustains one byte every 7+RD clocks.
        assign accept  = req_in[ch] && ((state_q == IDLE && !busy_q) || state_q == DONE);

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:    if (busy_q) state_d = ALO;
                ALO:     state_d = RISE;
                RISE:    state_d = AHI;
                AHI:     state_d = FALL;
                FALL:    state_d = TURN;
                TURN:    state_d = READ;
                READ:    if (last_rd) state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        // Bus outputs are registered from state_d so they line up with the state they belong to.
        always_ff @(posedge CLK_8M) begin
            if (RESET) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                addr_q  <= '0;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                mpx_q   <= 1'b0;
                oe_n_q  <= 1'b1;
                ad_oe_q <= 1'b0;
                ad_q    <= '0;
                data_q  <= '0;
                side_q  <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= (state_q == READ && !last_rd) ? cnt_q + 4'd1 : 4'd0;
                if (accept) begin
                    addr_q <= addr_in[24*ch +: 24];
                end
                if (accept) begin
                    busy_q <= 1'b1;
                end else if (state_q == DONE) begin
                    busy_q <= 1'b0;
                end
                valid_q <= (state_d == DONE);
                mpx_q   <= (state_d == RISE) || (state_d == AHI);
                oe_n_q  <= (state_d != READ);
                ad_oe_q <= state_d inside {ALO, RISE, AHI, FALL};
                if (state_d == ALO) begin
                    ad_q   <= addr_q[7:0];
                    side_q <= addr_q[LB-1:8];
                end
                if (state_d == AHI) begin
                    ad_q   <= addr_q[LB+7:LB];
                    side_q <= addr_q[LB+SW+7:LB+8];
                end
                if (state_q == READ && last_rd) begin
                    data_q <= ad_in[8*ch +: 8];
                end
            end
        end

        // Only the A channel has RA_U; it changes in the high phase only.
        if (ch == 0) begin : g_upper
            logic [3:0] upper_q;
            always_ff @(posedge CLK_8M) begin
                if (RESET) begin
                    upper_q <= '0;
                end else if (state_d == AHI) begin
                    upper_q <= addr_q[23:20];
                end
            end
        end
    end

    assign bus.A_BUSY  = g_ch[0].busy_q;
    assign bus.A_DATA  = g_ch[0].data_q;
    assign bus.A_VALID = g_ch[0].valid_q;
    assign bus.RMPX    = g_ch[0].mpx_q;
    assign bus.RA_L    = g_ch[0].side_q;
    assign bus.RA_U    = g_ch[0].g_upper.upper_q;
    assign bus.nSDROE  = g_ch[0].oe_n_q;
    assign RAD         = g_ch[0].ad_oe_q ? g_ch[0].ad_q : 8'hzz;

`ifdef VROM_PCMB_EN
    assign bus.B_BUSY  = g_ch[1].busy_q;
    assign bus.B_DATA  = g_ch[1].data_q;
    assign bus.B_VALID = g_ch[1].valid_q;
    assign bus.PMPX    = g_ch[1].mpx_q;
    assign bus.PA      = g_ch[1].side_q;
    assign bus.nSDPOE  = g_ch[1].oe_n_q;
    assign PAD         = g_ch[1].ad_oe_q ? g_ch[1].ad_q : 8'hzz;
`endif

endmodule

// File: tb/tb_ym_vrom_mux.sv
// tb/tb_ym_vrom_mux.sv - scoreboard bench for ym_vrom_mux with cartridge latch/ROM model
module tb_ym_vrom_mux;
    localparam int RD  = 2;
    localparam int RDB = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ym_vrom_mux_if bus_if ();
    wire [7:0] rad;
`ifdef VROM_PCMB_EN
    wire [7:0] pad;
`endif

    ym_vrom_mux #(.RD_CYCLES(RD), .PCMB_RD_CYCLES(RDB)) dut (
        .CLK_8M (clk),
        .RESET  (rst),
        .bus    (bus_if),
        .RAD    (rad)
`ifdef VROM_PCMB_EN
        ,
        .PAD    (pad)
`endif
    );

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
        int          cyc;
    } exp_t;

    exp_t sb_a[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        if (a == 24'h5A3C7E) return 8'hC3;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    // Cartridge: low latch on RMPX rise, high latch on RMPX fall; ROM answers while nSDROE low.
    logic [9:0]  lat_lo = '0;
    logic [13:0] lat_hi = '0;
    wire  [23:0] lat_a = {lat_hi, lat_lo};
    always @(posedge bus_if.RMPX) lat_lo = {bus_if.RA_L, rad};
    always @(negedge bus_if.RMPX) lat_hi = {bus_if.RA_U, bus_if.RA_L, rad};
    assign rad = !bus_if.nSDROE ? rom_byte(lat_a) : 8'hzz;

    int   mpx_edges = 0;
    int   roe_low = 0;
    logic prev_mpx = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mpx_edges = 0;
            roe_low   = 0;
            prev_mpx  = bus_if.RMPX;
        end else begin
            if (bus_if.RMPX != prev_mpx) mpx_edges++;
            prev_mpx = bus_if.RMPX;
            if (!bus_if.nSDROE) begin
                roe_low++;
                check("rad_driven_in_read", {31'd0, dut.g_ch[0].ad_oe_q}, 32'd0);
            end
            if (bus_if.A_VALID) begin
                if (sb_a.size() == 0) begin
                    check("a_unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb_a.pop_front();
                    check("a_data", {24'd0, bus_if.A_DATA}, {24'd0, e.data});
                    check("a_latched_addr", {8'd0, lat_a}, {8'd0, e.addr});
                    check("a_latency", cyc, e.cyc);
                    check("a_rmpx_edges", mpx_edges, 2);
                    check("a_roe_low_clocks", roe_low, RD);
                end
                mpx_edges = 0;
                roe_low   = 0;
            end
        end
    end

`ifdef VROM_PCMB_EN
    exp_t        sb_b[$];
    logic [11:0] latb_lo = '0;
    logic [11:0] latb_hi = '0;
    wire  [23:0] lat_b = {latb_hi, latb_lo};
    always @(posedge bus_if.PMPX) latb_lo = {bus_if.PA, pad};
    always @(negedge bus_if.PMPX) latb_hi = {bus_if.PA, pad};
    assign pad = !bus_if.nSDPOE ? rom_byte(lat_b) : 8'hzz;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_if.B_VALID) begin
            if (sb_b.size() == 0) begin
                check("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb_b.pop_front();
                check("b_data", {24'd0, bus_if.B_DATA}, {24'd0, e.data});
                check("b_latched_addr", {8'd0, lat_b}, {8'd0, e.addr});
                check("b_latency", cyc, e.cyc);
            end
        end
    end
`endif

    task automatic wait_a_idle();
        int n = 0;
        while (bus_if.A_BUSY && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_idle_wait", {31'd0, n < 100}, 32'd1);
    endtask

    task automatic drain_a(input string tag);
        int n = 0;
        while (sb_a.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, sb_a.size(), 0);
    endtask

    task automatic a_issue(input logic [23:0] addr);
        wait_a_idle();
        bus_if.A_ADDR = addr;
        bus_if.A_REQ  = 1'b1;
        @(negedge clk);
        check("a_busy_after_accept", {31'd0, bus_if.A_BUSY}, 32'd1);
        sb_a.push_back('{addr, rom_byte(addr), cyc + 6 + RD});
        bus_if.A_REQ  = 1'b0;
        bus_if.A_ADDR = ~addr;
    endtask

    initial begin
        logic [23:0] a0;
        int n;
        a0 = 24'h5A3C7E;
        bus_if.A_REQ  = 1'b1;
        bus_if.A_ADDR = a0;
`ifdef VROM_PCMB_EN
        bus_if.B_REQ  = 1'b0;
        bus_if.B_ADDR = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, bus_if.A_BUSY},  32'd0);
        check("rst_valid", {31'd0, bus_if.A_VALID}, 32'd0);
        check("rst_data",  {24'd0, bus_if.A_DATA},  32'd0);
        check("rst_rmpx",  {31'd0, bus_if.RMPX},    32'd0);
        check("rst_ra_l",  {30'd0, bus_if.RA_L},    32'd0);
        check("rst_ra_u",  {28'd0, bus_if.RA_U},    32'd0);
        check("rst_nsdroe", {31'd0, bus_if.nSDROE}, 32'd1);
        check("rst_rad_oe", {31'd0, dut.g_ch[0].ad_oe_q}, 32'd0);
`ifdef VROM_PCMB_EN
        check("rst_b_busy",   {31'd0, bus_if.B_BUSY}, 32'd0);
        check("rst_b_nsdpoe", {31'd0, bus_if.nSDPOE}, 32'd1);
        check("rst_pa",       {28'd0, bus_if.PA},     32'd0);
`endif

        // Request held through reset is taken on the first clock out of reset.
        rst = 1'b0;
        @(negedge clk);
        check("a_busy_first_clock", {31'd0, bus_if.A_BUSY}, 32'd1);
        sb_a.push_back('{a0, rom_byte(a0), cyc + 6 + RD});
        bus_if.A_REQ  = 1'b0;
        bus_if.A_ADDR = 24'h000000;
        @(negedge clk);
        check("alo_rad",  {24'd0, rad},         {24'd0, a0[7:0]});
        check("alo_ra_l", {30'd0, bus_if.RA_L}, {30'd0, a0[9:8]});
        check("alo_rmpx", {31'd0, bus_if.RMPX}, 32'd0);
        @(negedge clk);
        check("rise_rmpx", {31'd0, bus_if.RMPX}, 32'd1);
        @(negedge clk);
        check("ahi_rad",  {24'd0, rad},         {24'd0, a0[17:10]});
        check("ahi_ra_l", {30'd0, bus_if.RA_L}, {30'd0, a0[19:18]});
        check("ahi_ra_u", {28'd0, bus_if.RA_U}, {28'd0, a0[23:20]});
        @(negedge clk);
        check("fall_rmpx", {31'd0, bus_if.RMPX}, 32'd0);
        @(negedge clk);
        check("turn_nsdroe", {31'd0, bus_if.nSDROE}, 32'd1);
        drain_a("drain_first");

        // Held request: 000000 then FFFFFF, nine clocks apart; address change after accept ignored.
        wait_a_idle();
        bus_if.A_ADDR = 24'h000000;
        bus_if.A_REQ  = 1'b1;
        @(negedge clk);
        sb_a.push_back('{24'h000000, rom_byte(24'h000000), cyc + 6 + RD});
        sb_a.push_back('{24'hFFFFFF, rom_byte(24'hFFFFFF), cyc + 13 + 2 * RD});
        bus_if.A_ADDR = 24'hFFFFFF;
        repeat (7 + RD) @(negedge clk);
        bus_if.A_REQ  = 1'b0;
        bus_if.A_ADDR = 24'h123123;
        drain_a("drain_held");

        // Request pulse while busy must not start another transfer.
        a_issue(24'h3C00F1);
        repeat (3) @(negedge clk);
        bus_if.A_ADDR = 24'h777777;
        bus_if.A_REQ  = 1'b1;
        @(negedge clk);
        bus_if.A_REQ  = 1'b0;
        drain_a("drain_pulse");
        repeat (12) @(negedge clk);
        check("no_extra_transfer", {31'd0, bus_if.A_BUSY}, 32'd0);

        // Reset during READ aborts without a valid pulse.
        a_issue(24'h0ACE55);
        n = 0;
        while (bus_if.nSDROE && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("reach_read", {31'd0, bus_if.nSDROE}, 32'd0);
        rst = 1'b1;
        void'(sb_a.pop_back());
        @(negedge clk);
        check("abort_nsdroe", {31'd0, bus_if.nSDROE}, 32'd1);
        check("abort_rad_oe", {31'd0, dut.g_ch[0].ad_oe_q}, 32'd0);
        check("abort_valid",  {31'd0, bus_if.A_VALID}, 32'd0);
        check("abort_busy",   {31'd0, bus_if.A_BUSY},  32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        a_issue(24'h800001);
        drain_a("drain_after_reset");

        // Assorted addresses.
        for (int i = 0; i < 6; i++) begin
            a_issue(24'($urandom));
        end
        drain_a("drain_random");

`ifdef VROM_PCMB_EN
        // A and B launched together complete independently.
        wait_a_idle();
        bus_if.A_ADDR = 24'h123456;
        bus_if.B_ADDR = 24'hABCDEF;
        bus_if.A_REQ  = 1'b1;
        bus_if.B_REQ  = 1'b1;
        @(negedge clk);
        sb_a.push_back('{24'h123456, rom_byte(24'h123456), cyc + 6 + RD});
        sb_b.push_back('{24'hABCDEF, rom_byte(24'hABCDEF), cyc + 6 + RDB});
        bus_if.A_REQ  = 1'b0;
        bus_if.B_REQ  = 1'b0;
        drain_a("drain_ab");
        n = 0;
        while (sb_b.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_b", sb_b.size(), 0);
`endif

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
